// File: rtl/seg_scan_hex_if.sv
// rtl/seg_scan_hex_if.sv - display data in / segment and digit-enable pins out for seg_scan_hex
interface seg_scan_hex_if #(
   parameter int N_DIGITS = 4
);
   logic                  en;
   logic [4*N_DIGITS-1:0] value;
   logic [N_DIGITS-1:0]   dp;
   logic                  lz_en;
   logic [7:0]            seg;
   logic [N_DIGITS-1:0]   an;

   // Core side: owns the display register, reads back the pin state
   modport master (
      output en,
      output value,
      output dp,
      output lz_en,
      input  seg,
      input  an
   );

   // Display driver side
   modport slave (
      input  en,
      input  value,
      input  dp,
      input  lz_en,
      output seg,
      output an
   );
endinterface

// File: rtl/seg_scan_hex.sv
// rtl/seg_scan_hex.sv - time-multiplexed hex driver for an N-digit common-anode seven-segment display
module seg_scan_hex #(
   parameter int N_DIGITS = 4,
   parameter int SCAN_DIV = 1000
) (
   input  logic               clk,
   input  logic               rst,
   seg_scan_hex_if.slave      bus
);

   // A width of zero would appear for single-digit or divide-by-one builds; keep one bit.
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

   logic [PRE_W-1:0]        r_presc;
   logic [IDX_W-1:0]        r_idx;
   logic [4*N_DIGITS-1:0]   r_sh_value;
   logic [N_DIGITS-1:0]     r_sh_dp;
   logic                    r_sh_lz;
   logic [7:0]              r_seg;
   logic [N_DIGITS-1:0]     r_an;

   logic                    w_presc_wrap;
   logic                    w_frame_end;
   logic [N_DIGITS-1:0]     w_zero_from;
   logic [7:0]              w_seg_next;
   logic [N_DIGITS-1:0]     w_an_next;

   // Active-low a..g pattern for one hex nibble (0 = segment lit).
   function automatic logic [6:0] f_decode(input logic [3:0] nib);
      logic [6:0] pat;
      pat = 7'b1111111;
      case (nib)
         4'h0: pat = 7'b0000001;
         4'h1: pat = 7'b1001111;
         4'h2: pat = 7'b0010010;
         4'h3: pat = 7'b0000110;
         4'h4: pat = 7'b1001100;
         4'h5: pat = 7'b0100100;
         4'h6: pat = 7'b0100000;
         4'h7: pat = 7'b0001111;
         4'h8: pat = 7'b0000000;
         4'h9: pat = 7'b0000100;
         4'hA: pat = 7'b0001000;
         4'hB: pat = 7'b1100000;
         4'hC: pat = 7'b0110001;
         4'hD: pat = 7'b1000010;
         4'hE: pat = 7'b0110000;
         4'hF: pat = 7'b0111000;
      endcase
      return pat;
   endfunction

   assign w_presc_wrap = (r_presc == PRE_LAST);
   // The snapshot is taken on the edge that returns the scan to digit 0,
   // so every frame is drawn from one consistent set of inputs.
   assign w_frame_end  = w_presc_wrap && (r_idx == IDX_LAST);

   // Dwell prescaler and digit index; the index moves only when the prescaler wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc <= '0;
         r_idx   <= '0;
      end else begin
         if (w_presc_wrap) begin
            r_presc <= '0;
            if (r_idx == IDX_LAST) begin
               r_idx <= '0;
            end else begin
               r_idx <= r_idx + IDX_W'(1);
            end
         end else begin
            r_presc <= r_presc + PRE_W'(1);
         end
      end
   end

   // Anti-tearing shadow of the display inputs, refreshed once per frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sh_value <= '0;
         r_sh_dp    <= '0;
         r_sh_lz    <= 1'b0;
      end else if (w_frame_end) begin
         r_sh_value <= bus.value;
         r_sh_dp    <= bus.dp;
         r_sh_lz    <= bus.lz_en;
      end
   end

   // w_zero_from[k] is set when shadow nibbles k..N_DIGITS-1 are all zero.
   always_comb begin
      logic run_zero;
      w_zero_from = '0;
      run_zero    = 1'b1;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         run_zero       = run_zero & (r_sh_value[4*k +: 4] == 4'h0);
         w_zero_from[k] = run_zero;
      end
   end

   // Next segment/anode pattern for the current slot; blank unless the digit is shown.
   // An index with no matching digit falls through to the blank default.
   always_comb begin
      w_seg_next = 8'hFF;
      w_an_next  = '1;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            // Digit 0 is never suppressed so an all-zero value still shows "0".
            if (bus.en && !(r_sh_lz && (k > 0) && w_zero_from[k])) begin
               w_seg_next   = {f_decode(r_sh_value[4*k +: 4]), ~r_sh_dp[k]};
               w_an_next[k] = 1'b0;
            end
         end
      end
   end

   // Registered pin drivers: one cycle behind the index/shadow they were computed from.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg <= 8'hFF;
         r_an  <= '1;
      end else begin
         r_seg <= w_seg_next;
         r_an  <= w_an_next;
      end
   end

   assign bus.seg = r_seg;
   assign bus.an  = r_an;

endmodule

// File: tb/tb_seg_scan_hex.sv
// tb/tb_seg_scan_hex.sv - directed self-checking bench for seg_scan_hex
module tb_seg_scan_hex;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   always #5 clk = ~clk;

   // Main instance: 4 digits, 4-cycle dwell
   seg_scan_hex_if #(.N_DIGITS(4)) if0 ();
   seg_scan_hex #(.N_DIGITS(4), .SCAN_DIV(4)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0.slave)
   );

   // Corner: index advances every cycle
   seg_scan_hex_if #(.N_DIGITS(4)) if1 ();
   seg_scan_hex #(.N_DIGITS(4), .SCAN_DIV(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   // Corner: single digit
   seg_scan_hex_if #(.N_DIGITS(1)) if2 ();
   seg_scan_hex #(.N_DIGITS(1), .SCAN_DIV(4)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (if2.slave)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic expect0(input string tag, input logic [7:0] s, input logic [3:0] a);
      check_val({tag, ".seg"}, 32'(if0.seg), 32'(s));
      check_val({tag, ".an"},  32'(if0.an),  32'(a));
   endtask

   task automatic expect1(input string tag, input logic [7:0] s, input logic [3:0] a);
      check_val({tag, ".seg"}, 32'(if1.seg), 32'(s));
      check_val({tag, ".an"},  32'(if1.an),  32'(a));
   endtask

   task automatic expect2(input string tag, input logic [7:0] s, input logic a);
      check_val({tag, ".seg"}, 32'(if2.seg), 32'(s));
      check_val({tag, ".an"},  32'(if2.an),  32'(a));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      if0.en = 1'b1; if0.value = 16'h1234; if0.dp = 4'b0000; if0.lz_en = 1'b0;
      if1.en = 1'b1; if1.value = 16'h1234; if1.dp = 4'b0000; if1.lz_en = 1'b0;
      if2.en = 1'b1; if2.value = 4'h7;     if2.dp = 1'b1;    if2.lz_en = 1'b0;

      do_reset();
      expect0("rst0", 8'hFF, 4'hF);
      expect1("rst1", 8'hFF, 4'hF);
      expect2("rst2", 8'hFF, 1'b1);

      // Frame 0 shows the all-zero reset shadow
      step_to(1);
      expect0("f0.d0", 8'h03, 4'hE);
      expect1("c1.e1", 8'h03, 4'hE);
      expect2("c2.e1", 8'h03, 1'b0);
      step_to(4);
      expect1("c1.e4", 8'h03, 4'h7);
      step_to(5);
      expect0("f0.d1", 8'h03, 4'hD);
      expect1("c1.e5", 8'h99, 4'hE);
      expect2("c2.e5", 8'h1E, 1'b0);
      step_to(6);
      expect1("c1.e6", 8'h0D, 4'hD);
      step_to(16);
      expect0("f0.d3", 8'h03, 4'h7);

      // Frame 1: 1234
      step_to(17);
      expect0("f1.d0", 8'h99, 4'hE);
      step_to(20);
      expect0("f1.d0hold", 8'h99, 4'hE);
      if0.value = 16'hABCD; if0.dp = 4'b0101;
      step_to(21);
      expect0("f1.d1", 8'h0D, 4'hD);
      step_to(25);
      expect0("f1.d2", 8'h25, 4'hB);
      step_to(29);
      expect0("f1.d3", 8'h9F, 4'h7);

      // Frame 2: ABCD, dp on digits 0 and 2
      step_to(33);
      expect0("f2.d0", 8'h84, 4'hE);
      step_to(34);
      if0.value = 16'hEF89;
      step_to(37);
      expect0("f2.d1", 8'h63, 4'hD);
      step_to(41);
      expect0("f2.d2", 8'hC0, 4'hB);
      step_to(45);
      expect0("f2.d3", 8'h11, 4'h7);

      // Frame 3: EF89
      step_to(49);
      expect0("f3.d0", 8'h08, 4'hE);
      step_to(50);
      if0.value = 16'h0050; if0.dp = 4'b0000; if0.lz_en = 1'b1;
      step_to(53);
      expect0("f3.d1", 8'h01, 4'hD);
      step_to(57);
      expect0("f3.d2", 8'h70, 4'hB);
      step_to(61);
      expect0("f3.d3", 8'h61, 4'h7);

      // Frame 4: 0050 with leading-zero suppression
      step_to(65);
      expect0("f4.d0", 8'h03, 4'hE);
      step_to(66);
      if0.value = 16'h0000; if0.dp = 4'b0010;
      step_to(69);
      expect0("f4.d1", 8'h49, 4'hD);
      step_to(73);
      expect0("f4.d2", 8'hFF, 4'hF);
      step_to(77);
      expect0("f4.d3", 8'hFF, 4'hF);

      // Frame 5: 0000 suppressed except digit 0; dp of suppressed digit 1 stays off
      step_to(81);
      expect0("f5.d0", 8'h03, 4'hE);
      step_to(82);
      if0.value = 16'h1111; if0.dp = 4'b0000; if0.lz_en = 1'b0;
      step_to(85);
      expect0("f5.d1", 8'hFF, 4'hF);
      step_to(89);
      expect0("f5.d2", 8'hFF, 4'hF);

      // Frame 6: 1111, value changes to 2222 while digit 2 is selected
      step_to(97);
      expect0("f6.d0", 8'h9F, 4'hE);
      step_to(105);
      if0.value = 16'h2222;
      step_to(108);
      expect0("tear.d2", 8'h9F, 4'hB);
      step_to(109);
      expect0("tear.d3", 8'h9F, 4'h7);

      // Frame 7: 2222, en low for three cycles inside digit 1
      step_to(113);
      expect0("f7.d0", 8'h25, 4'hE);
      step_to(118);
      expect0("f7.d1", 8'h25, 4'hD);
      if0.en = 1'b0;
      step_to(119);
      expect0("en.off1", 8'hFF, 4'hF);
      step_to(121);
      expect0("en.off3", 8'hFF, 4'hF);
      if0.en = 1'b1;
      step_to(122);
      expect0("en.back", 8'h25, 4'hB);
      step_to(125);
      expect0("f7.d3", 8'h25, 4'h7);

      // Reset while digit 2 of frame 8 is selected
      step_to(138);
      do_reset();
      expect0("mrst0", 8'hFF, 4'hF);
      expect1("mrst1", 8'hFF, 4'hF);
      expect2("mrst2", 8'hFF, 1'b1);
      step_to(1);
      expect0("mrst0.e1", 8'h03, 4'hE);
      expect1("mrst1.e1", 8'h03, 4'hE);
      expect2("mrst2.e1", 8'h03, 1'b0);
      step_to(2);
      expect1("mrst1.e2", 8'h03, 4'hD);
      step_to(4);
      expect0("mrst0.e4", 8'h03, 4'hE);
      step_to(5);
      expect0("mrst0.e5", 8'h03, 4'hD);
      expect2("mrst2.e5", 8'h1E, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
